// File: rtl/dff_pipe_param.sv
// -----------------------------------------------------------------------------
// dff_pipe_param
//
// Elastic register pipeline: DEPTH stages of WIDTH-bit registers. Each stage
// has its own valid bit. Both ends use a valid/ready handshake. Empty stages
// always accept, so bubbles collapse and stalled data packs toward the output.
// A synchronous flush clears every stage, and an occupancy count is kept in a
// register next to the valid bits.
//
// Parameters
//   WIDTH  data width in bits (>= 1)
//   DEPTH  number of register stages (>= 1)
//   RESET  value loaded into every data stage on reset or flush
//
// Ports
//   clk        in   1                  rising-edge clock
//   rst        in   1                  asynchronous reset, active-high
//   flush      in   1                  synchronous clear of all stages
//   in_valid   in   1                  upstream data valid
//   in_ready   out  1                  stage 0 can accept this cycle
//   in_data    in   WIDTH              upstream data
//   out_valid  out  1                  last stage holds valid data
//   out_ready  in   1                  downstream accepts this cycle
//   out_data   out  WIDTH              last stage data
//   count      out  $clog2(DEPTH+1)    number of valid stages
// -----------------------------------------------------------------------------
module dff_pipe_param #(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 3,
    parameter logic [WIDTH-1:0] RESET = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q   [DEPTH];
    logic [WIDTH-1:0] data_d   [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] src_vld;
    logic [DEPTH-1:0] rdy;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    // Source of each stage: stage 0 is fed from the input port and every
    // other stage from the stage before it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
        if (gi == 0) begin : g_first
            assign src_vld[gi]  = in_valid;
            assign src_data[gi] = in_data;
        end else begin : g_rest
            assign src_vld[gi]  = vld_q[gi-1];
            assign src_data[gi] = data_q[gi-1];
        end
    end

    // The ready chain runs from the output back toward the input. A stage can
    // load when it is empty, or when its own content moves on at this edge.
    // in_valid does not feed this chain, so in_valid has no combinational
    // path to the out_* ports.
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = !vld_q[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = !vld_q[i] | rdy[i+1];
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            vld_d[i]  = vld_q[i];
            if (flush) begin
                // Flush wins over any transfer. An item offered this cycle
                // is dropped.
                data_d[i] = RESET;
                vld_d[i]  = 1'b0;
            end else if (rdy[i]) begin
                vld_d[i] = src_vld[i];
                // A bubble moving in leaves the old data in place.
                if (src_vld[i]) begin
                    data_d[i] = src_data[i];
                end
            end
        end
        count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_d = count_d + CW'(vld_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET;
            end
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_dff_pipe_param.sv
module tb_dff_pipe_param;

    localparam int         D  = 3;
    localparam logic [7:0] RV = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    always #5 clk = ~clk;

    dff_pipe_param #(.WIDTH(8), .DEPTH(D), .RESET(RV)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: the pipeline is a row of slots. Each cycle the output
    // item leaves if the sink is ready. Then, from the output side backward,
    // each item steps forward when the slot ahead is free. The input enters
    // slot 0 if slot 0 is free afterwards. exp_q holds the items still
    // expected at the output, in order.
    bit         m_occ [D];
    logic [7:0] m_dat [D];
    logic [7:0] exp_q [$];
    bit         prev_blocked = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) begin
            m_occ[i] = 1'b0;
            m_dat[i] = RV;
        end
        exp_q.delete();
    endtask

    // Called just after a falling edge: drive inputs, check outputs against
    // the model, advance the model across the rising edge.
    task automatic cycle(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
        bit         nocc [D];
        logic [7:0] ndat [D];
        int         cnt;
        bit         rdy0;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        nocc = m_occ;
        ndat = m_dat;
        if (ordy && m_occ[D-1]) nocc[D-1] = 1'b0;
        for (int i = D - 2; i >= 0; i--) begin
            if (nocc[i] && !nocc[i+1]) begin
                nocc[i+1] = 1'b1;
                ndat[i+1] = ndat[i];
                nocc[i]   = 1'b0;
            end
        end
        rdy0 = !nocc[0];
        cnt = 0;
        for (int i = 0; i < D; i++) cnt += int'(m_occ[i]);
        chk("in_ready", 32'(in_ready), 32'(rdy0));
        chk("out_valid", 32'(out_valid), 32'(m_occ[D-1]));
        chk("out_data", 32'(out_data), 32'(m_dat[D-1]));
        chk("count", 32'(count), 32'(cnt));
        if (out_valid && ordy) begin
            if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
            else chk("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
        end
        $display("cyc %0d: in v=%b d=%h rdy=%b fl=%b | out v=%b d=%h ordy=%b | cnt=%0d",
                 cyc, iv, d, in_ready, fl, out_valid, out_data, ordy, count);
        if (fl) begin
            for (int i = 0; i < D; i++) begin
                nocc[i] = 1'b0;
                ndat[i] = RV;
            end
            exp_q.delete();
        end else if (iv && rdy0) begin
            nocc[0] = 1'b1;
            ndat[0] = d;
            exp_q.push_back(d);
        end
        prev_blocked = iv && !rdy0 && !fl;
        @(posedge clk);
        m_occ = nocc;
        m_dat = ndat;
        cyc++;
        @(negedge clk);
    endtask

    initial begin : main
        int         first;
        int         seen;
        logic [7:0] rd;
        logic       riv;

        // 1. Reset held while the clock runs and in_valid is high.
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'h55; out_ready = 1'b0;
        model_reset();
        repeat (4) begin
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'(RV));
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end
        rst = 1'b0;

        // 2. Stream 01..08 with the sink always ready.
        first = -1; seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) begin
                if (first < 0) first = k;
                seen++;
            end
            cycle(k < 8, 8'(k + 1), 1'b1, 1'b0);
        end
        chk("latency", 32'(first), 32'd3);
        chk("stream_items", 32'(seen), 32'd8);

        // 3. Sink stalled: three items fit, the fourth is held back.
        cycle(1'b1, 8'h10, 1'b0, 1'b0);
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        cycle(1'b1, 8'h13, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd3);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        // 4. Full with the sink ready: one pop and one push on the same edge.
        cycle(1'b1, 8'h13, 1'b1, 1'b0);
        chk("full_pushpop_count", 32'(count), 32'd3);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // 5. An isolated item collapses to the last stage and stays there.
        cycle(1'b1, 8'h2A, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("collapse_count", 32'(count), 32'd1);
        chk("collapse_valid", 32'(out_valid), 32'd1);
        chk("collapse_data", 32'(out_data), 32'h2A);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        chk("collapse_hold", 32'(out_data), 32'h2A);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // 6. Flush with two items inside and 77 being offered.
        cycle(1'b1, 8'h31, 1'b0, 1'b0);
        cycle(1'b1, 8'h32, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_data", 32'(out_data), 32'(RV));
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomised traffic with occasional flushes. Blocked offers are
        // held stable, as upstream is required to do.
        rd = 8'h00;
        for (int k = 0; k < 300; k++) begin
            if (prev_blocked) begin
                riv = 1'b1;
            end else begin
                riv = ($urandom_range(0, 3) != 0);
                rd  = 8'($urandom);
            end
            cycle(riv, rd, ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
        end

        // Asynchronous reset raised between clock edges takes effect at once.
        cycle(1'b1, 8'h41, 1'b0, 1'b0);
        cycle(1'b1, 8'h42, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_count", 32'(count), 32'd0);
        chk("async_rst_data", 32'(out_data), 32'(RV));
        chk("async_rst_ready", 32'(in_ready), 32'd1);
        model_reset();
        prev_blocked = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
